// File: rtl/alu_pkg.sv
// Shared ALU-side types: default datapath width and the issue/capture FSM states.
package alu_pkg;
    localparam int WIDTH_DEF = 32;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        HOLD   = 2'd2
    } state_e;
endpackage

// File: rtl/slt_lt_fixup.sv
// Turns the comparator's raw difference sign into a true signed/unsigned less-than.
module slt_lt_fixup (
    input  logic x_msb,
    input  logic y_msb,
    input  logic d,
    input  logic is_unsigned,
    output logic lt
);
    // When the MSBs differ, the difference sign can be wrong; the MSBs decide directly.
    always_comb begin
        lt = d;
        if (x_msb != y_msb)
            lt = is_unsigned ? y_msb : x_msb;
    end
endmodule

// File: rtl/slt_sequencer.sv
// Handshaked issue/capture stage around an external ripple-carry SLT comparator:
// holds operands for SETTLE_CYCLES, samples, corrects and presents the result.
module slt_sequencer
    import alu_pkg::*;
#(
    parameter int WIDTH         = WIDTH_DEF,
    parameter int SETTLE_CYCLES = 4,
    parameter int CNT_W         = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_x,
    input  logic [WIDTH-1:0] in_y,
    input  logic             in_unsigned,
    output logic [WIDTH-1:0] cmp_x,
    output logic [WIDTH-1:0] cmp_y,
    input  logic             cmp_set,
    input  logic             cmp_overflow,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result,
    output logic             out_overflow,
    output logic             ovf_sticky,
    input  logic             ovf_clear,
    output logic [CNT_W-1:0] op_count
);
    localparam logic [1:0] ST_IDLE   = IDLE;
    localparam logic [1:0] ST_SETTLE = SETTLE;
    localparam logic [1:0] ST_HOLD   = HOLD;
    localparam int CW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

    generate
        if (SETTLE_CYCLES < 1) begin : g_bad_settle
            $error("slt_sequencer: SETTLE_CYCLES must be >= 1");
        end
    endgenerate

    logic [1:0]    state;
    logic [CW-1:0] cnt;
    logic          mode;
    logic          lt;
    logic          accept;
    logic          sample;
    logic          handoff;

    assign in_ready = (state == ST_IDLE) | ((state == ST_HOLD) & out_ready);
    assign accept   = in_valid & in_ready;
    assign sample   = (state == ST_SETTLE) && (cnt == '0);
    assign handoff  = out_valid & out_ready;

    slt_lt_fixup u_fixup (
        .x_msb       (cmp_x[WIDTH-1]),
        .y_msb       (cmp_y[WIDTH-1]),
        .d           (cmp_set),
        .is_unsigned (mode),
        .lt          (lt)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= ST_IDLE;
            cnt          <= '0;
            mode         <= 1'b0;
            cmp_x        <= '0;
            cmp_y        <= '0;
            out_valid    <= 1'b0;
            out_result   <= '0;
            out_overflow <= 1'b0;
            ovf_sticky   <= 1'b0;
            op_count     <= '0;
        end else begin
            if (handoff)
                op_count <= op_count + CNT_W'(1);

            // A sampled overflow outranks a clear arriving on the same edge.
            if (sample && cmp_overflow)
                ovf_sticky <= 1'b1;
            else if (ovf_clear)
                ovf_sticky <= 1'b0;

            case (state)
                ST_SETTLE: begin
                    if (cnt != '0) begin
                        cnt <= cnt - CW'(1);
                    end else begin
                        out_result   <= {{(WIDTH-1){1'b0}}, lt};
                        out_overflow <= cmp_overflow;
                        out_valid    <= 1'b1;
                        state        <= ST_HOLD;
                    end
                end
                ST_HOLD: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= ST_IDLE;
                    end
                end
                ST_IDLE: ;
                default: state <= ST_IDLE;
            endcase

            // Accept overrides the HOLD->IDLE exit so handoff and new issue share a cycle.
            if (accept) begin
                cmp_x <= in_x;
                cmp_y <= in_y;
                mode  <= in_unsigned;
                cnt   <= CW'(SETTLE_CYCLES - 1);
                state <= ST_SETTLE;
            end
        end
    end
endmodule

// File: tb/tb_slt_sequencer.sv
// Directed bench for slt_sequencer with a behavioural comparator that outputs
// inverted garbage until its inputs have been stable for SETTLE-1 cycles.
module tb_slt_sequencer;
    localparam int W      = 32;
    localparam int SETTLE = 4;
    localparam int CW     = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [W-1:0]  in_x = '0;
    logic [W-1:0]  in_y = '0;
    logic          in_unsigned = 1'b0;
    logic [W-1:0]  cmp_x, cmp_y;
    logic          cmp_set, cmp_overflow;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [W-1:0]  out_result;
    logic          out_overflow;
    logic          ovf_sticky;
    logic          ovf_clear = 1'b0;
    logic [CW-1:0] op_count;

    int checks = 0;
    int errors = 0;
    int exp_cnt = 0;

    always #5 clk = ~clk;

    slt_sequencer #(.WIDTH(W), .SETTLE_CYCLES(SETTLE), .CNT_W(CW)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_x(in_x), .in_y(in_y), .in_unsigned(in_unsigned),
        .cmp_x(cmp_x), .cmp_y(cmp_y), .cmp_set(cmp_set), .cmp_overflow(cmp_overflow),
        .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
        .out_overflow(out_overflow), .ovf_sticky(ovf_sticky), .ovf_clear(ovf_clear),
        .op_count(op_count)
    );

    // Behavioural ripple comparator with settle delay.
    logic [W-1:0] px = '0, py = '0;
    int           age = 0;
    logic [W:0]   diff;
    logic         chg, settled;
    assign diff         = {1'b0, cmp_x} + {1'b0, ~cmp_y} + 33'd1;
    assign chg          = (cmp_x != px) || (cmp_y != py);
    assign settled      = !chg && (age >= SETTLE - 1);
    assign cmp_set      = settled ? diff[W-1] : ~diff[W-1];
    assign cmp_overflow = settled ? diff[W]   : ~diff[W];
    always @(posedge clk) begin
        age <= chg ? 1 : ((age < 1000) ? age + 1 : age);
        px  <= cmp_x;
        py  <= cmp_y;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    task automatic issue(input logic [W-1:0] x, input logic [W-1:0] y, input logic u);
        @(negedge clk);
        in_x = x; in_y = y; in_unsigned = u; in_valid = 1'b1;
        chk("issue_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_result(input string tag, input logic [W-1:0] x, input logic [W-1:0] y,
                               input logic exp_lt, input logic exp_ovf);
        repeat (SETTLE - 1) @(posedge clk);
        #1 chk({tag, "_early"}, 32'(out_valid), 32'd0);
        @(posedge clk); #1;
        chk({tag, "_vld"}, 32'(out_valid), 32'd1);
        chk({tag, "_res"}, out_result, {31'd0, exp_lt});
        chk({tag, "_ovf"}, 32'(out_overflow), 32'(exp_ovf));
        chk({tag, "_cmpx"}, cmp_x, x);
        chk({tag, "_cmpy"}, cmp_y, y);
    endtask

    task automatic handoff;
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        exp_cnt = (exp_cnt + 1) % 16;
        chk("handoff_cnt", 32'(op_count), 32'(exp_cnt));
        chk("handoff_vld", 32'(out_valid), 32'd0);
    endtask

    task automatic op(input string tag, input logic [W-1:0] x, input logic [W-1:0] y,
                      input logic u, input logic exp_lt, input logic exp_ovf);
        issue(x, y, u);
        wait_result(tag, x, y, exp_lt, exp_ovf);
        handoff();
    endtask

    logic [W-1:0] held;

    initial begin
        #1;
        chk("rst_vld", 32'(out_valid), 32'd0);
        chk("rst_cnt", 32'(op_count), 32'd0);
        chk("rst_cmpx", cmp_x, 32'd0);
        chk("rst_res", out_result, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1 chk("rst_in_ready", 32'(in_ready), 32'd1);

        // Signed
        op("s_1_7", 32'd1, 32'd7, 1'b0, 1'b1, 1'b0);
        op("s_7_1", 32'd7, 32'd1, 1'b0, 1'b0, 1'b1);
        op("s_m1_1", 32'hFFFF_FFFF, 32'd1, 1'b0, 1'b1, 1'b1);
        // Unsigned and MSB-differs corner
        op("u_m1_1", 32'hFFFF_FFFF, 32'd1, 1'b1, 1'b0, 1'b1);
        op("s_min_max", 32'h8000_0000, 32'h7FFF_FFFF, 1'b0, 1'b1, 1'b1);
        op("u_min_max", 32'h8000_0000, 32'h7FFF_FFFF, 1'b1, 1'b0, 1'b1);

        // Backpressure then back-to-back accept
        issue(32'd2, 32'd3, 1'b0);
        wait_result("bp", 32'd2, 32'd3, 1'b1, 1'b0);
        held = out_result;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("bp_vld", 32'(out_valid), 32'd1);
            chk("bp_res", out_result, held);
            chk("bp_in_ready", 32'(in_ready), 32'd0);
        end
        @(negedge clk);
        out_ready = 1'b1; in_valid = 1'b1;
        in_x = 32'd9; in_y = 32'd4; in_unsigned = 1'b1;
        #1 chk("b2b_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk); #1;
        out_ready = 1'b0; in_valid = 1'b0;
        exp_cnt = (exp_cnt + 1) % 16;
        chk("b2b_cnt", 32'(op_count), 32'(exp_cnt));
        chk("b2b_vld", 32'(out_valid), 32'd0);
        chk("b2b_in_ready", 32'(in_ready), 32'd0);
        wait_result("b2b", 32'd9, 32'd4, 1'b0, 1'b1);
        handoff();

        // Reset mid-SETTLE
        issue(32'd3, 32'd9, 1'b0);
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        chk("mrst_cmpx", cmp_x, 32'd0);
        chk("mrst_cmpy", cmp_y, 32'd0);
        chk("mrst_res", out_result, 32'd0);
        chk("mrst_ovf", 32'(out_overflow), 32'd0);
        chk("mrst_vld", 32'(out_valid), 32'd0);
        chk("mrst_sticky", 32'(ovf_sticky), 32'd0);
        chk("mrst_cnt", 32'(op_count), 32'd0);
        exp_cnt = 0;
        @(negedge clk);
        rst_n = 1'b1;
        #1 chk("mrst_in_ready", 32'(in_ready), 32'd1);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("mrst_no_vld", 32'(out_valid), 32'd0);
        end

        // Sticky overflow
        op("st_no_ovf", 32'd1, 32'd7, 1'b0, 1'b1, 1'b0);
        chk("st_clear0", 32'(ovf_sticky), 32'd0);
        op("st_ovf", 32'd7, 32'd1, 1'b0, 1'b0, 1'b1);
        chk("st_set", 32'(ovf_sticky), 32'd1);
        issue(32'd5, 32'd2, 1'b0);
        repeat (SETTLE - 1) @(posedge clk);
        @(negedge clk);
        ovf_clear = 1'b1;
        @(posedge clk); #1;
        ovf_clear = 1'b0;
        chk("st_set_wins", 32'(ovf_sticky), 32'd1);
        chk("st_vld", 32'(out_valid), 32'd1);
        handoff();
        @(negedge clk);
        ovf_clear = 1'b1;
        @(negedge clk);
        ovf_clear = 1'b0;
        chk("st_cleared", 32'(ovf_sticky), 32'd0);

        // Counter wrap at CNT_W=4
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        exp_cnt = 0;
        for (int i = 0; i < 17; i++)
            op("wrap", 32'(i), 32'd8, 1'b1, (i < 8) ? 1'b1 : 1'b0, (i >= 8) ? 1'b1 : 1'b0);
        chk("wrap_final", 32'(op_count), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got running exp finished");
        $fatal(1, "timeout");
    end
endmodule
